// File: rtl/group_mac_stream_pkg.sv
// Shared types and helpers for the group MAC stream block and its lanes.
package group_mac_stream_pkg;

    typedef enum logic {StFresh, StAccum} acc_state_e;

    function automatic int unsigned prod_width(input int unsigned img_w, input int unsigned ker_w);
        return img_w + ker_w;
    endfunction

endpackage

// File: rtl/mac_sat_lane.sv
// One MAC lane: masked signed multiply (S2), then saturating accumulate with sticky overflow (S3).
module mac_sat_lane
    import group_mac_stream_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 16,
    parameter int unsigned KER_WIDTH = 16,
    parameter int unsigned ACC_WIDTH = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [IMG_WIDTH-1:0] s1_ma,
    input  logic signed [KER_WIDTH-1:0] s1_mb,
    input  logic                        s1_mask,
    input  logic                        s2_val,
    input  logic                        s2_last,
    output logic        [ACC_WIDTH-1:0] result,
    output logic                        ovf
);

    localparam int unsigned PROD_WIDTH = prod_width(IMG_WIDTH, KER_WIDTH);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [PROD_WIDTH-1:0] a_ext, b_ext, prod_d, prod_q;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic        [ACC_WIDTH:0]    sum;
    logic        [ACC_WIDTH-1:0]  sat, acc_d, acc_q, result_q;
    logic                         ovf_now, ovf_acc_d, ovf_acc_q, ovf_q;
    acc_state_e                   state_q;

    // Operands widened up front so the product is computed at full width.
    assign a_ext    = {{KER_WIDTH{s1_ma[IMG_WIDTH-1]}}, s1_ma};
    assign b_ext    = {{IMG_WIDTH{s1_mb[KER_WIDTH-1]}}, s1_mb};
    assign prod_d   = s1_mask ? a_ext * b_ext : '0;
    assign prod_ext = ACC_WIDTH'(prod_q);

    // One guard bit: overflow when the two top bits of the sum disagree.
    assign sum     = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
    assign ovf_now = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign sat     = ovf_now ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];

    always_comb begin
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        if (s2_val) begin
            if (state_q == StFresh) begin
                acc_d     = prod_ext;
                ovf_acc_d = 1'b0;
            end else begin
                acc_d     = sat;
                ovf_acc_d = ovf_acc_q | ovf_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q    <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            state_q   <= StFresh;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else if (en) begin
            prod_q <= prod_d;
            if (s2_val) begin
                acc_q     <= acc_d;
                ovf_acc_q <= ovf_acc_d;
                state_q   <= s2_last ? StFresh : StAccum;
                if (s2_last) begin
                    result_q <= acc_d;
                    ovf_q    <= ovf_acc_d;
                end
            end
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/group_mac_stream.sv
// Group of signed MAC lanes fed by a valid/ready term stream; one held result per dot-product.
module group_mac_stream
    import group_mac_stream_pkg::*;
#(
    parameter int unsigned GROUP_NB  = 4,
    parameter int unsigned IMG_WIDTH = 16,
    parameter int unsigned KER_WIDTH = 16,
    parameter int unsigned ACC_WIDTH = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] ma,
    input  logic [GROUP_NB*KER_WIDTH-1:0] mb,
    input  logic [GROUP_NB-1:0]           mask,
    input  logic                          in_val,
    input  logic                          in_last,
    output logic                          in_rdy,
    output logic [GROUP_NB*ACC_WIDTH-1:0] result,
    output logic [GROUP_NB-1:0]           ovf,
    output logic                          out_val,
    input  logic                          out_rdy
);

    logic                          en;
    logic [GROUP_NB*IMG_WIDTH-1:0] s1_ma_q;
    logic [GROUP_NB*KER_WIDTH-1:0] s1_mb_q;
    logic [GROUP_NB-1:0]           s1_mask_q;
    logic                          s1_val_q, s1_last_q, s2_val_q, s2_last_q, out_val_q;

    // A held, unaccepted result freezes the whole pipeline.
    assign en     = !(out_val_q && !out_rdy);
    assign in_rdy = en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s1_mask_q <= '0;
            s1_val_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_val_q  <= 1'b0;
            s2_last_q <= 1'b0;
            out_val_q <= 1'b0;
        end else if (en) begin
            s1_ma_q   <= ma;
            s1_mb_q   <= mb;
            s1_mask_q <= mask;
            s1_val_q  <= in_val;
            s1_last_q <= in_last;
            s2_val_q  <= s1_val_q;
            s2_last_q <= s1_last_q;
            out_val_q <= s2_val_q && s2_last_q;
        end
    end

    for (genvar i = 0; i < GROUP_NB; i++) begin : g_lane
        mac_sat_lane #(
            .IMG_WIDTH(IMG_WIDTH),
            .KER_WIDTH(KER_WIDTH),
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .s1_ma  (s1_ma_q[i*IMG_WIDTH +: IMG_WIDTH]),
            .s1_mb  (s1_mb_q[i*KER_WIDTH +: KER_WIDTH]),
            .s1_mask(s1_mask_q[i]),
            .s2_val (s2_val_q),
            .s2_last(s2_last_q),
            .result (result[i*ACC_WIDTH +: ACC_WIDTH]),
            .ovf    (ovf[i])
        );
    end

    assign out_val = out_val_q;

endmodule

// File: doc/group_mac_stream.md
Name: group_mac_stream

Overview:
- Next-generation MAC group: GROUP_NB signed multiply-accumulate lanes, fed by a valid/ready stream of image/kernel vectors.
- Each dot-product is delimited by in_last; the accumulator width is parametrised, with saturation and a per-lane sticky overflow flag.
- A per-term lane mask zeroes individual lanes' contributions.
- Sits between the image/kernel buffers and the activation/requantise stage; a held output register propagates backpressure upstream.

Parameters:
- GROUP_NB, 4, number of MAC lanes
- IMG_WIDTH, 16, signed image operand width
- KER_WIDTH, 16, signed kernel operand width
- ACC_WIDTH, 40, signed accumulator/result width per lane; must be >= IMG_WIDTH+KER_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- ma  in  GROUP_NB*IMG_WIDTH  image operands; lane i at [i*IMG_WIDTH +: IMG_WIDTH]
- mb  in  GROUP_NB*KER_WIDTH  kernel operands; lane i likewise
- mask  in  GROUP_NB  1 = lane i term contributes; 0 = lane i term treated as product 0
- in_val  in  1  input term valid
- in_last  in  1  final term of the current dot-product
- in_rdy  out  1  block accepts a term this cycle
- result  out  GROUP_NB*ACC_WIDTH  per-lane accumulated dot-product
- ovf  out  GROUP_NB  per-lane sticky saturation flag for the presented result
- out_val  out  1  result/ovf valid
- out_rdy  in  1  downstream accepts result

Behaviour:
- Reset (rst=0, asynchronous): all pipeline valids, accumulators, result, ovf and out_val clear to 0. The accumulation state returns to "fresh". Reset mid-dot-product discards partial sums.
- Global enable: en = !(out_val && !out_rdy). in_rdy = en. All stages advance only when en=1; when en=0, every register holds.
- A term is accepted when in_val && in_rdy.
- Pipeline (each step on an en edge):
  - S1: register ma, mb, mask, last, and a valid bit.
  - S2: signed product per lane, full IMG_WIDTH+KER_WIDTH width, forced to 0 where mask=0; registered with valid and last.
  - S3: accumulate.
- Accumulate (S2 valid):
  - Sign-extend the product to ACC_WIDTH.
  - If state is fresh: acc = product and ovf_int = 0. Otherwise: acc = sat(acc + product), and ovf_int |= overflow.
  - Saturation: clamp to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1), detected from ACC_WIDTH+1-bit sum sign bits.
  - If last: copy the final acc to result and the final ovf_int (including this term) to ovf; set out_val=1; state becomes fresh. Otherwise state becomes not-fresh.
- Latency: a last term accepted in cycle t gives out_val=1 in cycle t+3, absent stalls. Each stall cycle adds one.
- Bubbles: an invalid S2 leaves the accumulator unchanged. in_val may drop mid-dot-product without effect on the sum.
- Output: out_val stays high with result/ovf stable until out_val && out_rdy. On that cycle:
  - If a new last completes in the same edge, the new result loads and out_val stays 1.
  - Otherwise out_val drops to 0; result holds its last value.
- Single-term dot-product (in_last on the first term) is legal: result = product.
- Back-to-back dot-products need no gap cycles; throughput is 1 term/cycle while out_rdy=1.
- The upstream source must hold ma/mb/mask/in_last stable while in_val && !in_rdy.

Decomposition:
- Shared header group_mac_defs.vh:
  - `define macros for lane slice offsets
  - saturation limit constants as functions of ACC_WIDTH
  - localparam PROD_WIDTH = IMG_WIDTH+KER_WIDTH
- Sub-module mac_sat_lane, one per lane via generate:
  - S2 multiply/mask, S3 accumulate/saturate/ovf, fresh-state tracking
  - Lanes share en, valid and last from the top level
- The top level owns S1 registers, the enable/handshake and the output valid register.

Test Plan:
- Basic dot-product: 3 terms, all lanes ma={1,2,3}, mb={4,5,6}, mask=all 1, last on term 3, out_rdy=1 -> result=32 all lanes, ovf=0, out_val high 3 cycles after the last accept, for one cycle.
- Signed/mask: lane0 ma=-7,mb=3; lane1 ma=-32768,mb=-32768; lane2 mask=0, ma=5,mb=5; single term, last -> lane0=-21, lane1=1073741824, lane2=0.
- Saturation: ACC_WIDTH=32, lane0 adds 32767*32767 three times, last -> result=2147483647, ovf[0]=1; the next dot-product 1*1 -> result=1, ovf=0 (fresh reset).
- Backpressure: out_rdy=0 while two dot-products stream -> in_rdy drops the cycle out_val rises; the first result holds stable; releasing out_rdy yields both results in order, no term lost or duplicated.
- Bubbles/back-to-back: terms with random in_val gaps, then 1-term dot-products every cycle with out_rdy=1 -> sums match reference model; one result per cycle.
- Async reset mid-operation: rst=0 between terms 2 and 3, without a clock edge -> outputs 0 immediately. After release, a new 2-term dot-product 2*2+3*3 -> result=13 (no stale partial sum).
